// File: rtl/fifo_pkg.sv
// Shared constants for the 16x8 buffering FIFO: word/address widths, depth and pointer width.
package fifo_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 1 << ADDR_W;
  localparam int PTR_W  = ADDR_W + 1;

endpackage

// File: rtl/fifo_ptr.sv
// Wrap pointer with increment enable; the MSB is the lap bit used for full/empty detection.
module fifo_ptr
  import fifo_pkg::*;
#(
  parameter int W = PTR_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] ptr
);

  logic [W-1:0] ptr_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_reg <= '0;
    end else if (inc) begin
      ptr_reg <= ptr_reg + W'(1);
    end
  end

  assign ptr = ptr_reg;

endmodule

// File: rtl/fifo_ctrl_dual_port.sv
// FIFO controller driving ram_dual_port: push/pop handshake to RAM enables, occupancy flags, rd_valid.
// Optional sticky overflow/underflow outputs are built when FIFO_CTRL_ERR_EN is defined.
module fifo_ctrl_dual_port
  import fifo_pkg::*;
#(
  parameter int DATA_W = fifo_pkg::DATA_W,
  parameter int ADDR_W = fifo_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              pop,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              rd_valid,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_waddr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_re,
  output logic [ADDR_W-1:0] ram_raddr
`ifdef FIFO_CTRL_ERR_EN
  ,
  output logic              overflow,
  output logic              underflow
`endif
);

  localparam int PW = ADDR_W + 1;

  logic [PW-1:0] ptr_val [2];
  logic [1:0]    ptr_inc;
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic          push_ok;
  logic          pop_ok;
  logic          rd_valid_reg;

  // Index 0 is the write pointer, index 1 the read pointer.
  for (genvar gi = 0; gi < 2; gi++) begin : g_ptr
    fifo_ptr #(.W(PW)) u_ptr (
      .clk (clk),
      .rst (rst),
      .inc (ptr_inc[gi]),
      .ptr (ptr_val[gi])
    );
  end

  assign wptr = ptr_val[0];
  assign rptr = ptr_val[1];

  assign empty = (wptr == rptr);
  assign full  = (wptr[ADDR_W] != rptr[ADDR_W]) &&
                 (wptr[ADDR_W-1:0] == rptr[ADDR_W-1:0]);
  assign count = wptr - rptr;

  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign ptr_inc = {pop_ok, push_ok};

  // RAM samples these on the same edge that advances the pointers.
  assign ram_we    = push_ok;
  assign ram_waddr = wptr[ADDR_W-1:0];
  assign ram_wdata = wr_data;
  assign ram_re    = pop_ok;
  assign ram_raddr = rptr[ADDR_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid_reg <= 1'b0;
    end else begin
      rd_valid_reg <= pop_ok;
    end
  end

  assign rd_valid = rd_valid_reg;

`ifdef FIFO_CTRL_ERR_EN
  logic overflow_reg;
  logic underflow_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      overflow_reg  <= overflow_reg | (push & full);
      underflow_reg <= underflow_reg | (pop & empty);
    end
  end

  assign overflow  = overflow_reg;
  assign underflow = underflow_reg;
`endif

endmodule

// File: tb/tb_fifo_ctrl_dual_port.sv
// Bench for fifo_ctrl_dual_port with a behavioural dual-port RAM and a data scoreboard.
module tb_fifo_ctrl_dual_port;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       push = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       pop = 1'b0;
  logic       full;
  logic       empty;
  logic [4:0] count;
  logic       rd_valid;
  logic       ram_we;
  logic [3:0] ram_waddr;
  logic [7:0] ram_wdata;
  logic       ram_re;
  logic [3:0] ram_raddr;
`ifdef FIFO_CTRL_ERR_EN
  logic       overflow;
  logic       underflow;
`endif

  fifo_ctrl_dual_port dut (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .wr_data   (wr_data),
    .pop       (pop),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .rd_valid  (rd_valid),
    .ram_we    (ram_we),
    .ram_waddr (ram_waddr),
    .ram_wdata (ram_wdata),
    .ram_re    (ram_re),
    .ram_raddr (ram_raddr)
`ifdef FIFO_CTRL_ERR_EN
    ,
    .overflow  (overflow),
    .underflow (underflow)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural ram_dual_port: registered read.
  logic [7:0] mem [16];
  logic [7:0] ram_dout = 8'h00;

  always @(posedge clk) begin
    if (ram_we) mem[ram_waddr] <= ram_wdata;
    if (ram_re) ram_dout <= mem[ram_raddr];
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Reference model state
  int         m_w = 0;
  int         m_r = 0;
  logic       m_rv = 1'b0;
  logic       m_ovf = 1'b0;
  logic       m_unf = 1'b0;
  logic [7:0] sb_q[$];
  int         txn = 0;

  task automatic step(input logic s_rst, input logic s_push, input logic [7:0] s_data,
                      input logic s_pop);
    int   m_cnt;
    logic p_ok;
    logic q_ok;
    @(negedge clk);
    rst = s_rst;
    push = s_push;
    wr_data = s_data;
    pop = s_pop;
    m_cnt = (m_w - m_r) & 31;
    p_ok = s_push && (m_cnt < 16);
    q_ok = s_pop && (m_cnt > 0);
    #1;
    chk("ram_we", int'(ram_we), int'(p_ok));
    chk("ram_re", int'(ram_re), int'(q_ok));
    chk("ram_waddr", int'(ram_waddr), m_w % 16);
    chk("ram_raddr", int'(ram_raddr), m_r % 16);
    if (p_ok) chk("ram_wdata", int'(ram_wdata), int'(s_data));
    @(posedge clk);
    if (s_rst) begin
      m_w = 0;
      m_r = 0;
      m_rv = 1'b0;
      m_ovf = 1'b0;
      m_unf = 1'b0;
      sb_q.delete();
    end else begin
      if (s_push && m_cnt == 16) m_ovf = 1'b1;
      if (s_pop && m_cnt == 0) m_unf = 1'b1;
      if (p_ok) begin
        m_w = (m_w + 1) & 31;
        sb_q.push_back(s_data);
      end
      if (q_ok) m_r = (m_r + 1) & 31;
      m_rv = q_ok;
    end
    #1;
    m_cnt = (m_w - m_r) & 31;
    chk("count", int'(count), m_cnt);
    chk("empty", int'(empty), int'(m_cnt == 0));
    chk("full", int'(full), int'(m_cnt == 16));
    chk("rd_valid", int'(rd_valid), int'(m_rv));
`ifdef FIFO_CTRL_ERR_EN
    chk("overflow", int'(overflow), int'(m_ovf));
    chk("underflow", int'(underflow), int'(m_unf));
`endif
    if (rd_valid) begin
      if (sb_q.size() == 0) chk("sb_nonempty", 0, 1);
      else chk("rd_data", int'(ram_dout), int'(sb_q.pop_front()));
    end
    $display("txn %0d: rst=%0b push=%0b data=%02h pop=%0b -> count=%0d full=%0b empty=%0b rd_valid=%0b dout=%02h",
             txn, s_rst, s_push, s_data, s_pop, count, full, empty, rd_valid, ram_dout);
    txn++;
  endtask

  typedef struct {
    string      name;
    logic       rst;
    logic       push;
    logic       pop;
    logic [7:0] base;
    int         reps;
    int         exp_count;
    logic       exp_full;
    logic       exp_empty;
  } vec_t;

  vec_t vecs[12];

  initial begin
    vecs[0]  = '{"reset",      1'b1, 1'b0, 1'b0, 8'h00,  2,  0, 1'b0, 1'b1};
    vecs[1]  = '{"fill",       1'b0, 1'b1, 1'b0, 8'h10, 16, 16, 1'b1, 1'b0};
    vecs[2]  = '{"overflow",   1'b0, 1'b1, 1'b0, 8'hAA,  1, 16, 1'b1, 1'b0};
    vecs[3]  = '{"drain",      1'b0, 1'b0, 1'b1, 8'h00, 16,  0, 1'b0, 1'b1};
    vecs[4]  = '{"underflow",  1'b0, 1'b0, 1'b1, 8'h00,  1,  0, 1'b0, 1'b1};
    vecs[5]  = '{"push10",     1'b0, 1'b1, 1'b0, 8'h30, 10, 10, 1'b0, 1'b0};
    vecs[6]  = '{"pop10",      1'b0, 1'b0, 1'b1, 8'h00, 10,  0, 1'b0, 1'b1};
    vecs[7]  = '{"push12wrap", 1'b0, 1'b1, 1'b0, 8'h40, 12, 12, 1'b0, 1'b0};
    vecs[8]  = '{"pushpop8",   1'b0, 1'b1, 1'b1, 8'h60,  8, 12, 1'b0, 1'b0};
    vecs[9]  = '{"pop3",       1'b0, 1'b0, 1'b1, 8'h00,  3,  9, 1'b0, 1'b0};
    vecs[10] = '{"rst_pop",    1'b1, 1'b0, 1'b1, 8'h00,  1,  0, 1'b0, 1'b1};
    vecs[11] = '{"idle",       1'b0, 1'b0, 1'b0, 8'h00,  1,  0, 1'b0, 1'b1};

    for (int v = 0; v < 12; v++) begin
      for (int i = 0; i < vecs[v].reps; i++) begin
        step(vecs[v].rst, vecs[v].push, vecs[v].base + 8'(i), vecs[v].pop);
      end
      chk({vecs[v].name, "_count"}, int'(count), vecs[v].exp_count);
      chk({vecs[v].name, "_full"},  int'(full),  int'(vecs[v].exp_full));
      chk({vecs[v].name, "_empty"}, int'(empty), int'(vecs[v].exp_empty));
    end

    // Hand sequence: push with pop while empty must not fall through.
    step(1'b0, 1'b1, 8'hC3, 1'b1);
    chk("nofall_rd_valid", int'(rd_valid), 0);
    chk("nofall_count", int'(count), 1);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    chk("single_rd_valid", int'(rd_valid), 1);
    chk("single_data", int'(ram_dout), 8'hC3);

    // Hand sequence: push while full with pop, only the pop is taken.
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 8'h80 + 8'(i), 1'b0);
    step(1'b0, 1'b1, 8'hEE, 1'b1);
    chk("fullpp_count", int'(count), 15);
    chk("fullpp_data", int'(ram_dout), 8'h80);
    for (int i = 0; i < 15; i++) step(1'b0, 1'b0, 8'h00, 1'b1);
    chk("fullpp_drained", int'(empty), 1);
    step(1'b0, 1'b0, 8'h00, 1'b0);
    chk("tail_rd_valid", int'(rd_valid), 0);
    chk("sb_leftover", sb_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
